// File: rtl/mod_regwrite_sched_if.sv
// Writeback-op and regfile-write-port bundle for the register-write scheduler.
interface mod_regwrite_sched_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned NREGS = 16,
   parameter int unsigned DW    = 64
);
   localparam int unsigned RW = $clog2(NREGS);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             wb_valid;
   logic             wb_ready;
   logic             wb_we0;
   logic [RW-1:0]    wb_reg0;
   logic [DW-1:0]    wb_data0;
   logic             wb_we1;
   logic [RW-1:0]    wb_reg1;
   logic [DW-1:0]    wb_data1;
   logic             rf_we;
   logic [RW-1:0]    rf_waddr;
   logic [DW-1:0]    rf_wdata;
   logic [NREGS-1:0] busy;
   logic [CW-1:0]    fifo_count;

   // EX/WB side: offers ops, observes the regfile port and scoreboard.
   modport master (
      output flush, wb_valid, wb_we0, wb_reg0, wb_data0, wb_we1, wb_reg1, wb_data1,
      input  wb_ready, rf_we, rf_waddr, rf_wdata, busy, fifo_count
   );

   // Scheduler side.
   modport slave (
      input  flush, wb_valid, wb_we0, wb_reg0, wb_data0, wb_we1, wb_reg1, wb_data1,
      output wb_ready, rf_we, rf_waddr, rf_wdata, busy, fifo_count
   );
endinterface

// File: rtl/mod_regwrite_sched.sv
// Register-file write scheduler: queues up-to-two-write ops and drains one write per
// cycle onto a single regfile port, with a per-register pending-write scoreboard.
module mod_regwrite_sched #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned NREGS = 16,
   parameter int unsigned DW    = 64
) (
   input logic                 clk,
   input logic                 reset,
   mod_regwrite_sched_if.slave bus
);
   localparam int unsigned RW = $clog2(NREGS);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = $clog2(2 * DEPTH + 1);

   typedef enum logic [1:0] {StIdle, StW0, StW1} state_e;

   typedef struct packed {
      logic          we0;
      logic [RW-1:0] reg0;
      logic [DW-1:0] data0;
      logic          we1;
      logic [RW-1:0] reg1;
      logic [DW-1:0] data1;
   } op_t;

   op_t           fifo_q [DEPTH];
   op_t           op_in;
   op_t           head;
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   state_e        state_q, state_d;
   logic          rf_we_q, rf_we_d;
   logic [RW-1:0] rf_waddr_q, rf_waddr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;
   logic [SW-1:0] cnt_q [NREGS];
   logic [SW-1:0] cnt_d [NREGS];
   logic [NREGS-1:0] busy;
   logic          full, empty, ready, accept, enq, pop;

   assign op_in = '{we0: bus.wb_we0, reg0: bus.wb_reg0, data0: bus.wb_data0,
                    we1: bus.wb_we1, reg1: bus.wb_reg1, data1: bus.wb_data1};

   assign full   = (count_q == CW'(DEPTH));
   assign empty  = (count_q == '0);
   // No pass-through: a pop in the same cycle does not reopen a full queue.
   assign ready  = !full && !bus.flush;
   assign accept = bus.wb_valid && ready;
   // Ops without any write are handshaken but never take a slot.
   assign enq    = accept && (bus.wb_we0 || bus.wb_we1);
   assign head   = fifo_q[rd_ptr_q];

   // Drain FSM next state and next regfile-port values; StW1 means write0 of head is done.
   always_comb begin
      state_d    = state_q;
      rf_we_d    = 1'b0;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      pop        = 1'b0;
      if (empty) begin
         state_d = StIdle;
      end else if (state_q == StW1 || !head.we0) begin
         rf_we_d    = 1'b1;
         rf_waddr_d = head.reg1;
         rf_wdata_d = head.data1;
         pop        = 1'b1;
         state_d    = StW0;
      end else begin
         rf_we_d    = 1'b1;
         rf_waddr_d = head.reg0;
         rf_wdata_d = head.data0;
         if (head.we1) begin
            state_d = StW1;
         end else begin
            pop     = 1'b1;
            state_d = StW0;
         end
      end
      if (bus.flush) begin
         state_d = StIdle;
         rf_we_d = 1'b0;
         pop     = 1'b0;
      end
   end

   // Occupancy next state.
   always_comb begin
      count_d = count_q;
      if (enq && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!enq && pop) begin
         count_d = count_q - CW'(1);
      end
      if (bus.flush) begin
         count_d = '0;
      end
   end

   // Scoreboard next state: net of accepted writes and the write leaving the port.
   always_comb begin
      for (int r = 0; r < int'(NREGS); r++) begin
         cnt_d[r] = cnt_q[r]
                  + SW'(enq && bus.wb_we0 && (bus.wb_reg0 == RW'(r)))
                  + SW'(enq && bus.wb_we1 && (bus.wb_reg1 == RW'(r)))
                  - SW'(rf_we_q && (rf_waddr_q == RW'(r)));
         if (bus.flush) begin
            cnt_d[r] = '0;
         end
         busy[r] = (cnt_q[r] != '0);
      end
   end

   // Control, pointers, scoreboard and registered regfile port.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         for (int r = 0; r < int'(NREGS); r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         for (int r = 0; r < int'(NREGS); r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         if (bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         end
      end
   end

   // Op storage; validity is tracked by the pointers, so no reset needed.
   always_ff @(posedge clk) begin
      if (enq) fifo_q[wr_ptr_q] <= op_in;
   end

   assign bus.wb_ready   = ready;
   assign bus.rf_we      = rf_we_q;
   assign bus.rf_waddr   = rf_waddr_q;
   assign bus.rf_wdata   = rf_wdata_q;
   assign bus.busy       = busy;
   assign bus.fifo_count = count_q;
endmodule
